// File: rtl/jtbubl_romarb_pkg.sv
// Shared types and constants for the Bubble Bobble graphics ROM arbiter.
// Holds the arbiter FSM state type, requester indices and the watchdog limit.
// No ports; imported by jtbubl_romarb and jtbubl_romarb_slot.
package jtbubl_romarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requester indices, also used as the grant / last-served encoding.
  localparam logic SCR = 1'b0;
  localparam logic OBJ = 1'b1;

  // WAIT cycles allowed before the optional watchdog gives up on rom_ok.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/jtbubl_romarb_slot.sv
// Per-requester hold: tag, valid bit and data word of the last ROM access made
// for that requester, plus the registered ok flag against its current address.
// Ports: cs/addr from the requester; wr/wr_addr/wr_data from the arbiter;
// data/ok back to the requester; hit (combinational) tells the arbiter there
// is nothing to fetch.
module jtbubl_romarb_slot
  import jtbubl_romarb_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          hit
);

  logic [AW-1:0] tag;
  logic          valid;

  // The held word belongs to the address the requester is presenting now.
  assign hit = valid && (tag == addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      valid <= 1'b0;
      data  <= '0;
      ok    <= 1'b0;
    end else begin
      // Written even if the requester has moved on; ok then stays low
      // through the tag compare rather than by discarding the word.
      if (wr) begin
        tag   <= wr_addr;
        valid <= 1'b1;
        data  <= wr_data;
      end
      ok <= hit && cs;
    end
  end

endmodule

// File: rtl/jtbubl_romarb.sv
// Round-robin arbiter sharing one graphics SDRAM port between the tile (scr)
// and object (obj) fetchers; each gets its last word held with an ok flag.
// Ports: scr_*/obj_* requester channels, rom_* SDRAM channel, clk/rst_n.
// Optional macro JTBUBL_ROMARB_TIMEOUT_EN adds a WAIT watchdog and a 1-cycle
// timeout output pulse; without it WAIT lasts until rom_ok.
module jtbubl_romarb
  import jtbubl_romarb_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
`ifdef JTBUBL_ROMARB_TIMEOUT_EN
  output logic          timeout,
`endif
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  state_t        state, state_nxt;
  logic          grant, grant_nxt, last;
  logic          scr_hit, obj_hit;
  logic          scr_pend, obj_pend, any_pend;
  logic          expire, done_wr;
  logic [DW-1:0] wr_data;

  assign scr_pend = scr_cs && !scr_hit;
  assign obj_pend = obj_cs && !obj_hit;
  assign any_pend = scr_pend || obj_pend;

  // On a tie the requester not served last wins.
  always_comb begin
    grant_nxt = SCR;
    if (scr_pend && obj_pend) grant_nxt = (last == SCR) ? OBJ : SCR;
    else if (obj_pend)        grant_nxt = OBJ;
  end

`ifdef JTBUBL_ROMARB_TIMEOUT_EN
  logic [7:0] wdog;

  // wdog is 0 in the first WAIT cycle, so LIMIT-1 marks the LIMIT-th one.
  assign expire = (state == WAIT) && !rom_ok && (wdog == TIMEOUT_LIMIT - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      wdog    <= (state == WAIT) ? wdog + 8'd1 : 8'd0;
      timeout <= expire;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // rom_ok is only believed in WAIT: in ISSUE it may still describe the
  // previous address.
  assign done_wr = (state == WAIT) && (rom_ok || expire);
  assign wr_data = expire ? '0 : rom_data;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (rom_ok || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rom_cs/rom_addr are loaded on the IDLE->ISSUE edge so they are already
  // on the bus during ISSUE, and are frozen until the word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= SCR;
      last     <= OBJ;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      if (state == IDLE && any_pend) begin
        grant    <= grant_nxt;
        last     <= grant_nxt;
        rom_cs   <= 1'b1;
        rom_addr <= (grant_nxt == OBJ) ? obj_addr : scr_addr;
      end
      if (done_wr) rom_cs <= 1'b0;
    end
  end

  jtbubl_romarb_slot #(.AW(AW), .DW(DW)) u_scr_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (scr_cs),
    .addr    (scr_addr),
    .wr      (done_wr && grant == SCR),
    .wr_addr (rom_addr),
    .wr_data (wr_data),
    .data    (scr_data),
    .ok      (scr_ok),
    .hit     (scr_hit)
  );

  jtbubl_romarb_slot #(.AW(AW), .DW(DW)) u_obj_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (obj_cs),
    .addr    (obj_addr),
    .wr      (done_wr && grant == OBJ),
    .wr_addr (rom_addr),
    .wr_data (wr_data),
    .data    (obj_data),
    .ok      (obj_ok),
    .hit     (obj_hit)
  );

endmodule

// File: tb/tb_jtbubl_romarb.sv
// Self-checking bench for jtbubl_romarb: an SDRAM model with programmable
// latency and optional sticky rom_ok, a scoreboard of expected rom_addr
// grants and expected ok/data completions, and directed scenarios.
module tb_jtbubl_romarb;
  import jtbubl_romarb_pkg::*;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scr_cs = 1'b0, obj_cs = 1'b0;
  logic [AW-1:0] scr_addr = '0, obj_addr = '0;
  logic [DW-1:0] scr_data, obj_data;
  logic          scr_ok, obj_ok;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          rom_ok = 1'b0;
`ifdef JTBUBL_ROMARB_TIMEOUT_EN
  logic          timeout;
`endif

  jtbubl_romarb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scr_cs   (scr_cs),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
`ifdef JTBUBL_ROMARB_TIMEOUT_EN
    .timeout  (timeout),
`endif
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 18'h01234) return 32'hDEADBEEF;
    return {a[13:0], a} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- SDRAM model ----------------
  // A new address is seen one edge after rom_cs shows it, so an old rom_ok
  // (sticky mode) is still visible in the ISSUE cycle.
  int            lat = 0;
  bit            sticky = 1'b0;
  bit            model_off = 1'b0;
  bit            seen_vld = 1'b0;
  logic [AW-1:0] seen_addr = '0;
  int            cnt = 0;

  always @(posedge clk) begin
    if (model_off) begin
      rom_ok <= 1'b0;
    end else if (rom_cs && (!seen_vld || rom_addr != seen_addr)) begin
      seen_vld  <= 1'b1;
      seen_addr <= rom_addr;
      if (lat == 0) begin
        rom_ok   <= 1'b1;
        rom_data <= mem(rom_addr);
        cnt      <= 0;
      end else begin
        rom_ok <= 1'b0;
        cnt    <= lat;
      end
    end else if (!rom_cs) begin
      seen_vld <= 1'b0;
      cnt      <= 0;
      if (!sticky) rom_ok <= 1'b0;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        rom_ok   <= 1'b1;
        rom_data <= mem(seen_addr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } okexp_t;

  okexp_t        ok_q[$];
  logic [AW-1:0] rom_q[$];

  logic          p_scr_ok = 1'b0, p_obj_ok = 1'b0, p_rom_cs = 1'b0;
  logic [AW-1:0] p_rom_addr = '0;

  always @(negedge clk) begin
    okexp_t        e;
    logic [AW-1:0] ea;
    if (scr_ok && !p_scr_ok) begin
      if (ok_q.size() == 0) chk("scr_ok_unexpected", 1, 0);
      else begin
        e = ok_q.pop_front();
        chk("scr_ok_order", scr_ok ? SCR : OBJ, e.who);
        chk("scr_ok_addr", scr_addr, e.addr);
        chk("scr_data", scr_data, e.data);
      end
    end
    if (obj_ok && !p_obj_ok) begin
      if (ok_q.size() == 0) chk("obj_ok_unexpected", 1, 0);
      else begin
        e = ok_q.pop_front();
        chk("obj_ok_order", obj_ok ? OBJ : SCR, e.who);
        chk("obj_ok_addr", obj_addr, e.addr);
        chk("obj_data", obj_data, e.data);
      end
    end
    if (rom_cs && !p_rom_cs) begin
      if (rom_q.size() == 0) chk("rom_cs_unexpected", 1, 0);
      else begin
        ea = rom_q.pop_front();
        chk("rom_addr_seq", rom_addr, ea);
      end
    end
    if (rom_cs && p_rom_cs) chk("rom_addr_hold", rom_addr, p_rom_addr);
    p_scr_ok   <= scr_ok;
    p_obj_ok   <= obj_ok;
    p_rom_cs   <= rom_cs;
    p_rom_addr <= rom_addr;
  end

  // ---------------- helpers ----------------
  task automatic wait_ok(input bit is_obj, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_obj ? obj_ok : scr_ok) && n < bound);
    chk(is_obj ? "obj_ok_arrived" : "scr_ok_arrived", is_obj ? obj_ok : scr_ok, 1);
  endtask

  task automatic wait_rom_cs(input int bound);
    int n = 0;
    while (!rom_cs && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("rom_cs_seen", rom_cs, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_cs"}, rom_cs, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_scr_ok"}, scr_ok, 0);
    chk({tag, "_obj_ok"}, obj_ok, 0);
    chk({tag, "_scr_data"}, scr_data, 0);
    chk({tag, "_obj_data"}, obj_data, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single scr fetch at minimum SDRAM latency: ok exactly 4 cycles later.
    lat = 0;
    rom_q.push_back(18'h01234);
    ok_q.push_back('{SCR, 18'h01234, 32'hDEADBEEF});
    scr_addr = 18'h01234;
    scr_cs   = 1'b1;
    wait_ok(1'b0, 50, n);
    chk("t1_latency", n, 4);
    repeat (2) @(negedge clk);
    scr_cs = 1'b0;
    @(negedge clk);
    chk("t1_ok_drop", scr_ok, 0);
    chk("t1_data_hold", scr_data, 32'hDEADBEEF);

    // Re-request of the held address: one-cycle hit, no SDRAM access.
    ok_q.push_back('{SCR, 18'h01234, 32'hDEADBEEF});
    scr_cs = 1'b1;
    wait_ok(1'b0, 20, n);
    chk("hit_latency", n, 1);
    chk("hit_no_rom", rom_cs, 0);
    scr_cs = 1'b0;
    @(negedge clk);

    // Fresh reset so the tie-break starts from last=obj.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests: scr first, then obj. Sticky rom_ok keeps a stale
    // word on the bus when obj's grant starts.
    lat    = 3;
    sticky = 1'b1;
    rom_q.push_back(18'h00010);
    rom_q.push_back(18'h20000);
    ok_q.push_back('{SCR, 18'h00010, mem(18'h00010)});
    ok_q.push_back('{OBJ, 18'h20000, mem(18'h20000)});
    scr_addr = 18'h00010;
    obj_addr = 18'h20000;
    scr_cs   = 1'b1;
    obj_cs   = 1'b1;
    wait_ok(1'b0, 100, n);
    wait_ok(1'b1, 100, n);
    scr_cs = 1'b0;
    obj_cs = 1'b0;
    repeat (2) @(negedge clk);

    // Stale rom_ok=1 with obj's word while a new scr grant goes out.
    lat = 2;
    rom_q.push_back(18'h00444);
    ok_q.push_back('{SCR, 18'h00444, mem(18'h00444)});
    scr_addr = 18'h00444;
    scr_cs   = 1'b1;
    wait_ok(1'b0, 100, n);
    scr_cs = 1'b0;
    sticky = 1'b0;
    repeat (2) @(negedge clk);

    // obj address moves mid-WAIT: no ok for the old word, a second access.
    lat = 6;
    rom_q.push_back(18'h00100);
    rom_q.push_back(18'h00104);
    ok_q.push_back('{OBJ, 18'h00104, mem(18'h00104)});
    obj_addr = 18'h00100;
    obj_cs   = 1'b1;
    wait_rom_cs(20);
    repeat (2) @(negedge clk);
    obj_addr = 18'h00104;
    wait_ok(1'b1, 100, n);
    obj_cs = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT: everything clears at once, request reissues.
    lat = 8;
    rom_q.push_back(18'h00777);
    rom_q.push_back(18'h00777);
    ok_q.push_back('{SCR, 18'h00777, mem(18'h00777)});
    scr_addr = 18'h00777;
    scr_cs   = 1'b1;
    wait_rom_cs(20);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("wait_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ok(1'b0, 100, n);
    scr_cs = 1'b0;
    repeat (2) @(negedge clk);

`ifdef JTBUBL_ROMARB_TIMEOUT_EN
    // SDRAM never answers: watchdog completes the access with data 0.
    model_off = 1'b1;
    rom_q.push_back(18'h00900);
    ok_q.push_back('{SCR, 18'h00900, 32'h0});
    scr_addr = 18'h00900;
    scr_cs   = 1'b1;
    wait_rom_cs(20);
    n = 0;
    while (!timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 256);
    @(negedge clk);
    chk("to_pulse_width", timeout, 0);
    wait_ok(1'b0, 20, n);
    scr_cs    = 1'b0;
    model_off = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    chk("rom_q_drained", rom_q.size(), 0);
    chk("ok_q_drained", ok_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
